// File: rtl/mem_ahb_ws.sv
// mem_ahb_ws: AHB-Lite scratch memory slave with programmable wait states, ERROR response and write-to-read forwarding
module mem_ahb_ws #(
    parameter int P_SIZE_IN_BYTES = 8192,
    parameter int P_DW            = 32,
    parameter int P_WAIT          = 0,
    parameter int P_ERR_ALIGN     = 1
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            HSEL,
    input  logic [31:0]     HADDR,
    input  logic [1:0]      HTRANS,
    input  logic            HWRITE,
    input  logic [2:0]      HSIZE,
    input  logic [2:0]      HBURST,
    input  logic [P_DW-1:0] HWDATA,
    output logic [P_DW-1:0] HRDATA,
    output logic [1:0]      HRESP,
    input  logic            HREADYin,
    output logic            HREADYout
);
    localparam int BW = P_DW / 8;
    localparam int LW = $clog2(BW);
    localparam int AW = $clog2(P_SIZE_IN_BYTES);
    localparam int WW = (AW > LW) ? AW - LW : 1;
    localparam int DEPTH = P_SIZE_IN_BYTES / BW;
    localparam logic [2:0] MAX_SIZE = 3'(LW);
    localparam logic [2:0] WAIT_LD = (P_WAIT > 0) ? 3'(P_WAIT - 1) : 3'd0;
    localparam logic [1:0] S_IDLE = 2'd0, S_WAIT = 2'd1, S_ERR1 = 2'd2, S_ERR2 = 2'd3;

    logic [P_DW-1:0] mem_q [DEPTH];
    logic [1:0]      state_q, state_d;
    logic [2:0]      cnt_q, cnt_d;
    logic            pend_q, pend_d, wr_q, wr_d;
    logic [WW-1:0]   addr_q, addr_d, haddr_w, raddr;
    logic [BW-1:0]   strb_q, strb_d, strb;
    logic [P_DW-1:0] rdata_q, rdata_d, rword;
    logic [LW-1:0]   sz_mask, lane;
    logic            acc, legal, commit, rd_en;
    logic            unused;

    assign unused    = ^{HBURST, HTRANS[0], HADDR[31:AW]};
    assign HREADYout = (state_q == S_IDLE) || (state_q == S_ERR2);
    assign HRESP     = {1'b0, state_q[1]};  // both error states share the top state bit
    assign HRDATA    = rdata_q;
    assign acc       = HSEL && HTRANS[1] && HREADYin && HREADYout;
    assign commit    = pend_q && wr_q && (state_q == S_IDLE);
    assign haddr_w   = WW'(HADDR[AW-1:0] >> LW);

    always_comb begin
        sz_mask = '0;
        strb    = '0;
        for (int i = 0; i < LW; i++) sz_mask[i] = 3'(i) < HSIZE;
        lane = HADDR[LW-1:0] & ~sz_mask;
        for (int b = 0; b < BW; b++) strb[b] = (b >= int'(lane)) && (b < int'(lane) + (1 << HSIZE));
        legal = (HSIZE <= MAX_SIZE) && !((P_ERR_ALIGN != 0) && |(HADDR[LW-1:0] & sz_mask));
    end

    always_comb begin
        state_d = S_IDLE;
        cnt_d   = cnt_q;
        if (state_q == S_WAIT) begin
            state_d = (cnt_q == 3'd0) ? S_IDLE : S_WAIT;
            cnt_d   = (cnt_q == 3'd0) ? 3'd0 : cnt_q - 3'd1;
        end else if (state_q == S_ERR1) begin
            state_d = S_ERR2;
        end else if (acc) begin
            state_d = !legal ? S_ERR1 : ((P_WAIT > 0) ? S_WAIT : S_IDLE);
            cnt_d   = WAIT_LD;
        end
        pend_d = acc ? legal : (pend_q && state_q == S_WAIT);
        wr_d   = acc ? HWRITE : wr_q;
        addr_d = acc ? haddr_w : addr_q;
        strb_d = acc ? strb : strb_q;
    end

    // a read accepted while a write to the same word commits sees the write's bytes
    always_comb begin
        rd_en = (acc && legal && !HWRITE && P_WAIT == 0) ||
                (state_q == S_WAIT && cnt_q == 3'd0 && pend_q && !wr_q);
        raddr = (state_q == S_WAIT) ? addr_q : haddr_w;
        rword = mem_q[raddr];
        for (int b = 0; b < BW; b++)
            if (commit && addr_q == raddr && strb_q[b]) rword[8*b +: 8] = HWDATA[8*b +: 8];
        rdata_d = rd_en ? rword : rdata_q;
    end

    always_ff @(posedge HCLK) begin
        for (int b = 0; b < BW; b++)
            if (commit && strb_q[b]) mem_q[addr_q][8*b +: 8] <= HWDATA[8*b +: 8];
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_q <= S_IDLE;
            cnt_q   <= 3'd0;
            pend_q  <= 1'b0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            strb_q  <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            wr_q    <= wr_d;
            addr_q  <= addr_d;
            strb_q  <= strb_d;
            rdata_q <= rdata_d;
        end
    end
endmodule

// File: tb/tb_mem_ahb_ws.sv
// tb_mem_ahb_ws: two slave configurations driven by independent masters, checked against a byte-level memory model
module tb_mem_ahb_ws;
    logic        clk;
    logic        rstn [2];
    logic        hsel [2];
    logic        hwrite [2];
    logic [1:0]  htrans [2];
    logic [2:0]  hsize [2];
    logic [2:0]  hburst [2];
    logic [31:0] haddr [2];
    logic [63:0] hwdata [2];
    logic [31:0] hrdata0;
    logic [63:0] hrdata1;
    logic [1:0]  hresp0, hresp1;
    logic        hready0, hready1;
    logic [7:0]  mdl [2][8192];
    logic [63:0] last_rd [2];
    int          n_chk, n_err;

    mem_ahb_ws #(.P_SIZE_IN_BYTES(8192), .P_DW(32), .P_WAIT(0), .P_ERR_ALIGN(1)) u_dut0 (
        .HCLK(clk), .HRESETn(rstn[0]), .HSEL(hsel[0]), .HADDR(haddr[0]), .HTRANS(htrans[0]),
        .HWRITE(hwrite[0]), .HSIZE(hsize[0]), .HBURST(hburst[0]), .HWDATA(hwdata[0][31:0]),
        .HRDATA(hrdata0), .HRESP(hresp0), .HREADYin(hready0), .HREADYout(hready0));

    mem_ahb_ws #(.P_SIZE_IN_BYTES(1024), .P_DW(64), .P_WAIT(3), .P_ERR_ALIGN(0)) u_dut1 (
        .HCLK(clk), .HRESETn(rstn[1]), .HSEL(hsel[1]), .HADDR(haddr[1]), .HTRANS(htrans[1]),
        .HWRITE(hwrite[1]), .HSIZE(hsize[1]), .HBURST(hburst[1]), .HWDATA(hwdata[1]),
        .HRDATA(hrdata1), .HRESP(hresp1), .HREADYin(hready1), .HREADYout(hready1));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic int bw(int d); return d ? 8 : 4; endfunction
    function automatic int lg(int d); return d ? 3 : 2; endfunction
    function automatic int wt(int d); return d ? 3 : 0; endfunction
    function automatic int al(int d); return d ? 0 : 1; endfunction
    function automatic int sz(int d); return d ? 1024 : 8192; endfunction
    function automatic logic rdy(int d); return d ? hready1 : hready0; endfunction
    function automatic logic [1:0] rsp(int d); return d ? hresp1 : hresp0; endfunction
    function automatic logic [63:0] rdt(int d); return d ? hrdata1 : {32'h0, hrdata0}; endfunction

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic bit legal_m(int d, logic [31:0] a, logic [2:0] s);
        return int'(s) <= lg(d) && !(al(d) == 1 && a % (32'd1 << s) != 0);
    endfunction

    function automatic int ea_m(int d, logic [31:0] a, logic [2:0] s);
        int e = int'(a % 32'(sz(d)));
        return (al(d) == 1 || int'(s) > lg(d)) ? e : e - e % (1 << s);
    endfunction

    function automatic logic [63:0] word_m(int d, int e);
        logic [63:0] w = '0;
        int base = e - e % bw(d);
        for (int i = 0; i < bw(d); i++) w[8*i +: 8] = mdl[d][base + i];
        return w;
    endfunction

    task automatic write_m(input int d, input int e, input logic [2:0] s, input logic [63:0] wd);
        int lane = e % bw(d);
        for (int i = 0; i < (1 << s); i++) mdl[d][e + i] = wd[8*(lane + i) +: 8];
    endtask

    task automatic addr_ph(input int d, input logic [31:0] a, input logic w, input logic [2:0] s);
        hsel[d]   = 1'b1;
        htrans[d] = 2'b10;
        haddr[d]  = a;
        hwrite[d] = w;
        hsize[d]  = s;
        hburst[d] = 3'($urandom_range(0, 7));
    endtask

    task automatic xfer(input int d, input logic [31:0] a, input logic w, input logic [2:0] s,
                        input logic [63:0] wd, output logic [63:0] rd);
        int st = 0;
        logic [1:0] r0;
        bit ok = legal_m(d, a, s);
        int e = ea_m(d, a, s);
        string t = $sformatf("d%0d a=%h s=%0d w=%0d", d, a, s, w);
        @(negedge clk);
        addr_ph(d, a, w, s);
        @(negedge clk);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        haddr[d]  = $urandom;
        hwdata[d] = wd;
        r0 = rsp(d);
        while (!rdy(d) && st < 20) begin
            st++;
            @(negedge clk);
        end
        chk({t, " stall"}, 64'(st), ok ? 64'(wt(d)) : 64'd1);
        chk({t, " resp0"}, 64'(r0), ok ? 64'd0 : 64'd1);
        chk({t, " resp"}, 64'(rsp(d)), ok ? 64'd0 : 64'd1);
        if (ok && !w) last_rd[d] = word_m(d, e);
        if (ok && w) write_m(d, e, s, wd);
        chk({t, " rdata"}, rdt(d), last_rd[d]);
        rd = rdt(d);
    endtask

    task automatic b2b(input int d, input logic [31:0] a, input logic [2:0] s, input logic [63:0] wd);
        int st = 0;
        int e = ea_m(d, a, s);
        logic [31:0] ra = (a & ~32'(bw(d) - 1)) | 32'($urandom_range(0, bw(d) - 1));
        string t = $sformatf("d%0d b2b a=%h", d, a);
        @(negedge clk);
        addr_ph(d, a, 1'b1, s);
        @(negedge clk);
        hwdata[d] = wd;
        addr_ph(d, ra, 1'b0, 3'd0);
        while (!rdy(d) && st < 20) begin
            st++;
            @(negedge clk);
        end
        chk({t, " wstall"}, 64'(st), 64'(wt(d)));
        write_m(d, e, s, wd);
        @(negedge clk);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        st = 0;
        while (!rdy(d) && st < 20) begin
            st++;
            @(negedge clk);
        end
        chk({t, " rstall"}, 64'(st), 64'(wt(d)));
        chk({t, " resp"}, 64'(rsp(d)), 64'd0);
        last_rd[d] = word_m(d, e);
        chk({t, " rdata"}, rdt(d), last_rd[d]);
    endtask

    task automatic idl(input int d, input logic [31:0] a, input logic [63:0] wd);
        @(negedge clk);
        addr_ph(d, a, 1'b1, 3'd2);
        hsel[d]   = 1'($urandom_range(0, 1));
        htrans[d] = hsel[d] ? 2'($urandom_range(0, 1)) : 2'b10;
        @(negedge clk);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        hwdata[d] = wd;
        chk($sformatf("d%0d idle ready", d), 64'(rdy(d)), 64'd1);
        chk($sformatf("d%0d idle resp", d), 64'(rsp(d)), 64'd0);
        chk($sformatf("d%0d idle rdata", d), rdt(d), last_rd[d]);
    endtask

    task automatic rst_mid(input int d, input logic [31:0] a, input logic [63:0] wd);
        @(negedge clk);
        addr_ph(d, a, 1'b1, 3'(lg(d)));
        @(negedge clk);
        hsel[d]   = 1'b0;
        htrans[d] = 2'b00;
        hwdata[d] = wd;
        chk($sformatf("d%0d mid wait", d), 64'(rdy(d)), 64'd0);
        rstn[d] = 1'b0;
        #1;
        chk($sformatf("d%0d mid rst ready", d), 64'(rdy(d)), 64'd1);
        chk($sformatf("d%0d mid rst resp", d), 64'(rsp(d)), 64'd0);
        chk($sformatf("d%0d mid rst rdata", d), rdt(d), 64'd0);
        last_rd[d] = '0;
        @(negedge clk);
        rstn[d] = 1'b1;
    endtask

    task automatic run(input int d);
        logic [63:0] rd;
        logic [31:0] a;
        logic [2:0]  s;
        for (int i = 0; i < 128; i += bw(d)) xfer(d, 32'(i), 1'b1, 3'(lg(d)), {$urandom, $urandom}, rd);
        if (d == 0) begin
            xfer(0, 32'h10, 1'b1, 3'd2, 64'hDEADBEEF, rd);
            xfer(0, 32'h10, 1'b0, 3'd2, 64'd0, rd);
            chk("d0 deadbeef", rd, 64'hDEADBEEF);
            for (int i = 0; i < 4; i++) xfer(0, 32'h20 + 32'(i), 1'b1, 3'd0, 64'(32'h11 * (i + 1)) << (8 * i), rd);
            xfer(0, 32'h20, 1'b0, 3'd2, 64'd0, rd);
            chk("d0 bytes", rd, 64'h44332211);
            b2b(0, 32'h40, 3'd2, 64'hCAFEF00D);
            chk("d0 forward", rdt(0), 64'hCAFEF00D);
            xfer(0, 32'h01, 1'b1, 3'd1, 64'hFFFFFFFF, rd);
            xfer(0, 32'h00, 1'b1, 3'd3, 64'h5A5A5A5A5A5A5A5A, rd);
            xfer(0, 32'h00, 1'b0, 3'd2, 64'd0, rd);
        end else begin
            xfer(1, 32'h08, 1'b1, 3'd3, 64'h0123456789ABCDEF, rd);
            rst_mid(1, 32'h08, 64'hFEDCBA9876543210);
            xfer(1, 32'h08, 1'b0, 3'd3, 64'd0, rd);
            chk("d1 dropped", rd, 64'h0123456789ABCDEF);
            xfer(1, 32'h08 + 32'd1024 * 5, 1'b0, 3'd3, 64'd0, rd);
            chk("d1 alias", rd, 64'h0123456789ABCDEF);
            xfer(1, 32'h00, 1'b0, 3'd2, 64'd0, rd);
        end
        for (int n = 0; n < 150; n++) begin
            a = 32'($urandom_range(0, 127));
            if ($urandom_range(0, 3) == 0) a |= $urandom & ~32'(sz(d) - 1);
            s = ($urandom_range(0, 7) == 0) ? 3'($urandom_range(lg(d) + 1, 7)) : 3'($urandom_range(0, lg(d)));
            case ($urandom_range(0, 7))
                0: idl(d, a, {$urandom, $urandom});
                1: begin
                    s = 3'($urandom_range(0, lg(d)));
                    b2b(d, a & ~((32'd1 << s) - 32'd1), s, {$urandom, $urandom});
                end
                2, 3, 4: xfer(d, a, 1'b0, s, {$urandom, $urandom}, rd);
                default: xfer(d, a, 1'b1, s, {$urandom, $urandom}, rd);
            endcase
        end
    endtask

    initial begin
        n_chk = 0;
        n_err = 0;
        for (int d = 0; d < 2; d++) begin
            rstn[d]    = 1'b0;
            hsel[d]    = 1'b0;
            htrans[d]  = 2'b00;
            haddr[d]   = '0;
            hwrite[d]  = 1'b0;
            hsize[d]   = '0;
            hburst[d]  = '0;
            hwdata[d]  = '0;
            last_rd[d] = '0;
        end
        #2;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("d%0d reset ready", d), 64'(rdy(d)), 64'd1);
            chk($sformatf("d%0d reset resp", d), 64'(rsp(d)), 64'd0);
            chk($sformatf("d%0d reset rdata", d), rdt(d), 64'd0);
        end
        @(negedge clk);
        rstn[0] = 1'b1;
        rstn[1] = 1'b1;
        fork
            run(0);
            run(1);
        join
        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog expired");
    end
endmodule

// File: doc/mem_ahb_ws.md
Name: mem_ahb_ws

Overview:
- AHB-Lite slave memory; the next generation of the team's single-port AHB BRAM slave.
- Generalised in data-bus width and in programmable wait states.
- Adds a two-cycle ERROR response for illegal transfers, and write-to-read forwarding for back-to-back transfers.
- Sits on the AHB interconnect as a scratch/program memory behind a decoder-driven HSEL.

Parameters:
- P_SIZE_IN_BYTES, 8192: memory size in bytes; power of two, >= P_DW/8.
- P_DW, 32: HWDATA/HRDATA width; 32 or 64.
- P_WAIT, 0: extra wait cycles inserted in every OKAY data phase; 0..7.
- P_ERR_ALIGN, 1: 1 = misaligned transfers get an ERROR response; 0 = address low bits are masked to the transfer size.

Ports:
- HCLK, input, 1: clock.
- HRESETn, input, 1: reset, asynchronous, active-low.
- HSEL, input, 1: slave select.
- HADDR, input, 32: address; only the low log2(P_SIZE_IN_BYTES) bits index the memory.
- HTRANS, input, 2: transfer type.
- HWRITE, input, 1: 1 = write.
- HSIZE, input, 3: transfer size.
- HBURST, input, 3: accepted, ignored; each beat is handled independently.
- HWDATA, input, P_DW: write data, data phase.
- HRDATA, output, P_DW: read data.
- HRESP, output, 2: 2'b00 = OKAY, 2'b01 = ERROR.
- HREADYin, input, 1: bus ready.
- HREADYout, output, 1: slave ready.

Behaviour:
- Reset values (asynchronous): HREADYout=1, HRESP=2'b00, HRDATA=0, state=IDLE, wait counter=0, pending write cleared. Memory contents are not reset.
- Accept: an address phase is accepted on a rising edge where HSEL & HTRANS[1] & HREADYin & HREADYout.
  - On accept, HADDR, HWRITE and HSIZE are registered.
  - IDLE/BUSY, or HSEL=0, gives a zero-wait OKAY and no access.
- Illegal transfer, checked at accept:
  - HSIZE > log2(P_DW/8), or
  - P_ERR_ALIGN=1 and HADDR is not aligned to HSIZE.
- States: IDLE, WAIT, ERR1, ERR2.
  - IDLE to ERR1: accepted illegal transfer.
  - IDLE to WAIT: accepted legal transfer with P_WAIT>0; counter is loaded with P_WAIT-1.
  - IDLE stays IDLE: accepted legal transfer with P_WAIT=0; the data phase completes in the next cycle with HREADYout=1.
  - WAIT: HREADYout=0, HRESP=OKAY. Counter decrements; at 0, go to IDLE, and the following cycle is the completing data-phase cycle.
  - ERR1: HREADYout=0, HRESP=01. Always go to ERR2.
  - ERR2: HREADYout=1, HRESP=01. A new address phase may be accepted here; next state follows the IDLE rules.
  - The master may drive IDLE during ERR1; the slave ignores it.
  - An errored write never modifies memory.
- Byte lanes: little-endian; lane = HADDR[log2(P_DW/8)-1:0].
  - Write strobes are a contiguous 2^HSIZE-byte mask at that lane.
  - With P_ERR_ALIGN=0, the low bits are masked before the lane is computed.
- Writes: memory is written on the edge that ends the completing data phase (HREADYout=1), using HWDATA and the registered strobes.
- Reads:
  - The memory word is read synchronously on the edge entering the completing data-phase cycle.
  - For P_WAIT=0 this is the accept edge, so HRDATA is valid in the HREADYout=1 cycle.
  - HRDATA holds its last value otherwise; all byte lanes are returned.
- Forwarding, P_WAIT=0 only:
  - Applies when a read address phase is accepted on the same edge a write data phase to the same word completes.
  - HRDATA returns the stored word with the write's strobed bytes replaced by HWDATA.
  - With P_WAIT>0 the write has always committed before the read samples the memory, so no forwarding occurs.
- Address wrap: HADDR bits above log2(P_SIZE_IN_BYTES) are ignored; the memory aliases.
- Reset mid-transfer: any pending write is dropped; the state returns to IDLE immediately.

Test Plan:
- P_DW=32, P_WAIT=0: write word 0xDEADBEEF @0x10, then read @0x10 -> zero-wait, HRDATA=0xDEADBEEF, HRESP=00.
- Byte writes 0x11, 0x22, 0x33, 0x44 @0x20..0x23, then word read @0x20 -> HRDATA=0x44332211.
- Back-to-back: write word 0xCAFEF00D @0x40 immediately followed by read @0x40 (P_WAIT=0) -> HRDATA=0xCAFEF00D (forwarded).
- P_WAIT=3: read @0x0 -> HREADYout low 3 cycles, then high with data; writes show the same 3-cycle stall.
- P_ERR_ALIGN=1: halfword write @0x01 -> ERR1 (HREADYout=0, HRESP=01), then ERR2 (HREADYout=1, HRESP=01); word @0x00 unchanged. HSIZE=3 on P_DW=32 -> same ERROR response.
- P_DW=64: doubleword write 0x0123456789ABCDEF @0x08; assert HRESETn low mid-WAIT on a later write -> that write is dropped; the @0x08 readback still equals the original value.
